// File: rtl/systolic_result_drain.sv
// systolic_result_drain
//
// Result collector at the bottom edge of the systolic PE array. It waits for
// the pipeline to fill, captures one c_ab vector per cycle into a vector FIFO,
// and serializes the vectors lane by lane onto a valid/ready stream. The PE
// chain cannot stall, so capture never back-pressures: when the FIFO is full
// the vector is dropped and the sticky overflow flag is raised.
//
// Optional feature macro: DRAIN_SKEW_EN
//   defined   - lane i passes through VECTOR-1-i delay registers to undo the
//               diagonal wavefront; the fill count becomes ROWS+VECTOR-1.
//   undefined - all lanes are captured in the same cycle; fill count is ROWS.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   start      one-cycle pulse, operand injection for a tile begins
//   tile_len   result vectors in the tile, sampled with start
//   c_in       c_ab vector from the last PE row
//   out_ready  downstream ready
//   out_valid  out_data valid
//   out_data   result word
//   out_lane   lane index of out_data
//   out_last   last word of the tile
//   busy       high whenever the FSM is not in IDLE
//   overflow   sticky, a captured vector was dropped on a full FIFO
module systolic_result_drain #(
   parameter int REG_WIDTH = 16,
   parameter int VECTOR    = 6,
   parameter int ROWS      = 6,
   parameter int DEPTH     = 8
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                start,
   input  logic [7:0]                          tile_len,
   input  logic [VECTOR-1:0][REG_WIDTH-1:0]    c_in,
   input  logic                                out_ready,
   output logic                                out_valid,
   output logic [REG_WIDTH-1:0]                out_data,
   output logic [$clog2(VECTOR)-1:0]           out_lane,
   output logic                                out_last,
   output logic                                busy,
   output logic                                overflow
);

   localparam int LANE_W = $clog2(VECTOR);
   localparam int AW     = $clog2(DEPTH);
`ifdef DRAIN_SKEW_EN
   localparam int FILL_LEN = ROWS + VECTOR - 1;
`else
   localparam int FILL_LEN = ROWS;
`endif
   localparam int FW = $clog2(FILL_LEN + 1);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_FILL    = 2'd1;
   localparam logic [1:0] S_CAPTURE = 2'd2;
   localparam logic [1:0] S_DRAIN   = 2'd3;

   logic [1:0]                       state;
   logic [FW-1:0]                    fill_cnt;
   logic [7:0]                       cap_cnt;
   logic [7:0]                       len_q;
   logic [VECTOR-1:0][REG_WIDTH-1:0] cap_vec;
   logic [VECTOR-1:0][REG_WIDTH-1:0] mem [DEPTH];
   logic [AW:0]                      wr_ptr;
   logic [AW:0]                      rd_ptr;
   logic [VECTOR-1:0][REG_WIDTH-1:0] vec_q;
   logic [LANE_W-1:0]                lane_q;

   // ---------------------------------------------------------------- skew
`ifdef DRAIN_SKEW_EN
   for (genvar i = 0; i < VECTOR; i++) begin : g_lane
      localparam int D = VECTOR - 1 - i;
      if (D == 0) begin : g_pass
         assign cap_vec[i] = c_in[i];
      end else begin : g_dly
         logic [REG_WIDTH-1:0] dly [D];
         always_ff @(posedge clk) begin
            dly[0] <= c_in[i];
            for (int k = 1; k < D; k++) dly[k] <= dly[k-1];
         end
         assign cap_vec[i] = dly[D-1];
      end
   end
`else
   assign cap_vec = c_in;
`endif

   // ------------------------------------------------------------- control
   logic capturing, fifo_empty, fifo_full, last_lane, hs;
   logic ser_take, pop, bypass, push, drop, cap_end;

   assign capturing  = (state == S_CAPTURE);
   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                       (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign last_lane  = (lane_q == LANE_W'(VECTOR - 1));
   assign hs         = out_valid && out_ready;
   // The serializer can accept a new vector when idle, or in the very cycle
   // its last lane hands off, so consecutive vectors stream without a bubble.
   assign ser_take   = !out_valid || (hs && last_lane);
   assign pop        = ser_take && !fifo_empty;
   // An empty FIFO lets a fresh capture go straight into the serializer,
   // giving the one-cycle capture-to-output latency.
   assign bypass     = ser_take && fifo_empty && capturing;
   assign push       = capturing && !bypass && (!fifo_full || pop);
   assign drop       = capturing && !bypass && fifo_full && !pop;
   assign cap_end    = capturing && (cap_cnt == len_q - 8'd1);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         fill_cnt <= '0;
         cap_cnt  <= '0;
         len_q    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start && tile_len != 8'd0) begin
                  state    <= S_FILL;
                  len_q    <= tile_len;
                  fill_cnt <= '0;
               end
            end
            S_FILL: begin
               if (fill_cnt == FW'(FILL_LEN - 1)) begin
                  state   <= S_CAPTURE;
                  cap_cnt <= '0;
               end else begin
                  fill_cnt <= fill_cnt + 1'b1;
               end
            end
            S_CAPTURE: begin
               if (cap_end) state <= S_DRAIN;
               else         cap_cnt <= cap_cnt + 1'b1;
            end
            default: begin
               // Done once nothing is buffered and the final word handed off.
               if (fifo_empty && ser_take) state <= S_IDLE;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------- FIFO
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // NOTE: the storage array is left unreset; the pointers alone define
   // which entries are valid, and resetting it would cost a reset net per bit.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= cap_vec;
   end

   // ---------------------------------------------------------- serializer
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         lane_q    <= '0;
         vec_q     <= '0;
      end else if (ser_take) begin
         lane_q <= '0;
         if (pop) begin
            vec_q     <= mem[rd_ptr[AW-1:0]];
            out_valid <= 1'b1;
         end else if (bypass) begin
            vec_q     <= cap_vec;
            out_valid <= 1'b1;
         end else begin
            out_valid <= 1'b0;
         end
      end else if (hs) begin
         lane_q <= lane_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n)    overflow <= 1'b0;
      else if (drop) overflow <= 1'b1;
   end

   assign out_data = vec_q[lane_q];
   assign out_lane = lane_q;
   // In DRAIN no further captures can arrive, so an empty FIFO means the
   // vector in the serializer is the last one the tile will ever emit.
   assign out_last = out_valid && last_lane && fifo_empty && (state == S_DRAIN);
   assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_systolic_result_drain.sv
// Testbench for systolic_result_drain: randomized tiles, a scoreboard queue
// filled by the stimulus, and a separate monitor that checks each handshake.
module tb_systolic_result_drain;

   localparam int W     = 16;
   localparam int V     = 6;
   localparam int ROWS  = 6;
   localparam int DEPTH = 8;
   localparam int LW    = $clog2(V);
`ifdef DRAIN_SKEW_EN
   localparam bit SKEW = 1'b1;
`else
   localparam bit SKEW = 1'b0;
`endif
   localparam int FILL_LEN = SKEW ? ROWS + V - 1 : ROWS;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                start = 1'b0;
   logic [7:0]          tile_len = '0;
   logic [V-1:0][W-1:0] c_in = '0;
   logic                out_ready = 1'b0;
   logic                out_valid;
   logic [W-1:0]        out_data;
   logic [LW-1:0]       out_lane;
   logic                out_last;
   logic                busy;
   logic                overflow;

   systolic_result_drain #(
      .REG_WIDTH(W), .VECTOR(V), .ROWS(ROWS), .DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .tile_len(tile_len),
      .c_in(c_in), .out_ready(out_ready), .out_valid(out_valid),
      .out_data(out_data), .out_lane(out_lane), .out_last(out_last),
      .busy(busy), .overflow(overflow)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int nvec = 0;
   int nerr = 0;

   typedef struct {
      logic [W-1:0] data;
      int           lane;
      bit           last;
   } exp_t;

   exp_t sb[$];
   int   ready_mode = 0;        // 0 always ready, 1 toggle, 2 random, 3 held low
   int   first_valid_cyc = -1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Downstream ready generator.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            2:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
         endcase
      end
   end

   // Monitor: pops the scoreboard on every handshake, checks stall stability.
   bit           stall = 1'b0;
   logic [W-1:0] p_data;
   logic [LW-1:0] p_lane;
   logic         p_last;
   exp_t         got;

   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            stall = 1'b0;
         end else begin
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (stall) begin
               check("stall_valid", 32'(out_valid), 32'd1);
               check("stall_hold", {out_data, out_lane, out_last}, {p_data, p_lane, p_last});
            end
            if (out_valid && out_ready) begin
               if (sb.size() == 0) begin
                  nvec++;
                  nerr++;
                  $display("FAIL unexpected_word: got data %0h lane %0d with nothing expected",
                           out_data, out_lane);
               end else begin
                  got = sb.pop_front();
                  check("word_data", 32'(out_data), 32'(got.data));
                  check("word_lane", 32'(out_lane), 32'(got.lane));
                  check("word_last", 32'(out_last), 32'(got.last));
               end
            end
            stall  = out_valid && !out_ready;
            p_data = out_data;
            p_lane = out_lane;
            p_last = out_last;
         end
      end
   end

   // Issues one tile and queues its expected words. The buffer holds the FIFO
   // plus one vector in the serializer, so with ready held low the first
   // DEPTH+1 vectors survive; other modes use tiles that always fit.
   task automatic run_tile(input int len, input int mode, input bit cnt_data,
                           input bit extra_start, output int t0);
      logic [V-1:0][W-1:0] drv [64];
      exp_t e;
      int   n_off;
      int   kept;
      int   off;
      ready_mode = mode;
      n_off = FILL_LEN + 1 + len;
      @(posedge clk);
      #1;
      t0 = cyc;
      for (int o = 0; o < 64; o++)
         for (int i = 0; i < V; i++)
            drv[o][i] = cnt_data ? W'(t0 + o) : W'($urandom);
      kept = (mode == 3) ? ((len < DEPTH + 1) ? len : DEPTH + 1) : len;
      for (int j = 0; j < kept; j++) begin
         for (int i = 0; i < V; i++) begin
            off    = FILL_LEN + 1 + j - (SKEW ? V - 1 - i : 0);
            e.data = drv[off][i];
            e.lane = i;
            e.last = (j == kept - 1) && (i == V - 1);
            sb.push_back(e);
         end
      end
      for (int o = 0; o < n_off; o++) begin
         if (o > 0) begin
            @(posedge clk);
            #1;
         end
         start    = (o == 0) || (extra_start && o == 3);
         tile_len = (o == 0) ? 8'(len) : ((extra_start && o == 3) ? 8'd5 : 8'($urandom));
         c_in     = drv[o];
         if (o == 1) check("busy_after_start", 32'(busy), 32'(len != 0));
      end
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_idle(output int when);
      when = -1;
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         if (!busy && sb.size() == 0) begin
            when = cyc;
            break;
         end
      end
      if (when < 0) begin
         nvec++;
         nerr++;
         $display("FAIL idle_timeout: busy %0d, %0d words still expected", busy, sb.size());
         sb.delete();
      end
      ready_mode = 0;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int t0;
      int tb;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_valid", 32'(out_valid), 32'd0);
      check("reset_last", 32'(out_last), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_overflow", 32'(overflow), 32'd0);
      check("reset_data", 32'(out_data), 32'd0);
      check("reset_lane", 32'(out_lane), 32'd0);
      rst_n = 1'b1;

      // Basic tile with cycle-counter data and timing checks.
      first_valid_cyc = -1;
      run_tile(2, 0, 1'b1, 1'b0, t0);
      wait_idle(tb);
      check("first_valid_cycle", 32'(first_valid_cyc - t0), 32'(FILL_LEN + 2));
      check("busy_low_cycle", 32'(tb - t0), 32'(FILL_LEN + 14));

      // Toggling back-pressure.
      run_tile(2, 1, 1'b0, 1'b0, t0);
      wait_idle(tb);

      // Zero-length tile: nothing happens.
      run_tile(0, 0, 1'b0, 1'b0, t0);
      repeat (5) @(negedge clk);
      check("busy_zero_tile", 32'(busy), 32'd0);
      wait_idle(tb);

      // Start pulse during FILL must be ignored.
      run_tile(4, 2, 1'b0, 1'b1, t0);
      wait_idle(tb);

      // Random tiles under random back-pressure.
      for (int n = 0; n < 8; n++) begin
         run_tile($urandom_range(1, 9), $urandom_range(0, 2), 1'b0, 1'b0, t0);
         wait_idle(tb);
      end
      check("overflow_clear", 32'(overflow), 32'd0);

      // Overflow: ready held low through capture.
      run_tile(20, 3, 1'b0, 1'b0, t0);
      @(negedge clk);
      check("overflow_set", 32'(overflow), 32'd1);
      ready_mode = 0;
      wait_idle(tb);
      check("overflow_sticky", 32'(overflow), 32'd1);

      // Reset in DRAIN with a word pending.
      run_tile(3, 3, 1'b0, 1'b0, t0);
      check("pre_reset_valid", 32'(out_valid), 32'd1);
      check("pre_reset_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("midreset_outputs", {out_valid, out_last, busy, overflow, out_data, out_lane},
            '0);
      sb.delete();
      rst_n = 1'b1;
      ready_mode = 0;

      // A tile after the reset behaves like the basic one.
      first_valid_cyc = -1;
      run_tile(2, 0, 1'b1, 1'b0, t0);
      wait_idle(tb);
      check("post_reset_first_valid", 32'(first_valid_cyc - t0), 32'(FILL_LEN + 2));
      check("post_reset_busy_low", 32'(tb - t0), 32'(FILL_LEN + 14));

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/systolic_result_drain.md
# systolic_result_drain

Result collector at the bottom edge of the systolic PE array. It captures the `c_ab` accumulation vectors leaving the last PE row once the pipeline has filled, and buffers them in a vector FIFO. It then serializes them word by word onto a valid/ready stream toward the writeback path. The PE chain cannot be stalled, so capture is never back-pressured; FIFO overrun is flagged, not prevented.

## Interface
- `REG_WIDTH`, 16, width of one accumulator word
- `VECTOR`, 6, lanes per result vector (matches PE vector width)
- `ROWS`, 6, PE rows between operand injection and this block (fill latency in cycles)
- `DEPTH`, 8, FIFO depth in vectors (power of two, ≥2)

Ports:
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `start`  in  1  one-cycle pulse: operand injection for a tile begins this cycle
- `tile_len`  in  8  result vectors in the tile; sampled with `start`
- `c_in`  in  `REG_WIDTH` × [`VECTOR`-1:0]  `c_ab` vector from the last PE row
- `out_ready`  in  1  downstream ready
- `out_valid`  out  1  `out_data` valid
- `out_data`  out  `REG_WIDTH`  result word
- `out_lane`  out  $clog2(`VECTOR`)  lane index of `out_data`
- `out_last`  out  1  last word of the tile
- `busy`  out  1  high in any state other than IDLE
- `overflow`  out  1  sticky; a captured vector was dropped because the FIFO was full

## Operation
- FSM states: IDLE, FILL, CAPTURE, DRAIN.
- IDLE:
  - `start`=1 with `tile_len`≠0 → FILL. Latch `tile_len`; clear the fill counter.
  - `start`=1 with `tile_len`=0 → stay in IDLE. No output is produced.
  - `start` is ignored in every other state.
- FILL:
  - Count `ROWS` cycles (plus `VECTOR`-1 extra cycles when skew is enabled), then go to CAPTURE.
- CAPTURE:
  - Write one vector per cycle into the FIFO, `tile_len` cycles total, then go to DRAIN.
  - If the FIFO is full on a write cycle, drop the vector and set `overflow`. The capture count still advances.
- DRAIN:
  - When the FIFO is empty and the serializer is idle → IDLE.
- Serializer (runs in CAPTURE and DRAIN):
  - Pops the FIFO head and emits lanes 0..`VECTOR`-1 in order, one word per handshake (`out_valid` && `out_ready`).
  - The next vector is popped in the same cycle as the handshake of lane `VECTOR`-1, so there is no bubble between vectors.
  - `out_last`=1 on lane `VECTOR`-1 of the final vector of the tile. If trailing vectors were dropped, `out_last` is asserted on the last vector actually emitted.
- Simultaneous push and pop on a full FIFO is accepted; no overflow is flagged.
- Data is passed through unmodified; the FIFO is `VECTOR`×`REG_WIDTH` bits wide.
- `overflow` clears only on reset.

## Timing
- Reset (`rst_n`=0 at a clock edge):
  - State → IDLE; FIFO pointers and counters → 0.
  - `out_valid`, `out_last`, `busy`, `overflow`, `out_data`, `out_lane` → 0.
  - Reset mid-tile discards all buffered data; no partial handshake completes.
- `start` at cycle T:
  - `busy`=1 from T+1.
  - First capture at cycle T+`ROWS`+1 (T+`ROWS`+`VECTOR` with skew).
- Latency from capture to output: vector captured at cycle C gives `out_valid`=1 with lane 0 at C+1 at the earliest.
- Handshake rules:
  - While `out_valid`=1 and `out_ready`=0, `out_data`, `out_lane` and `out_last` hold stable.
  - `out_valid` never drops without a handshake.
- `busy` falls the cycle after the handshake with `out_last`=1. When every vector was dropped, it falls the cycle after CAPTURE ends.
- A new `start` is accepted in the cycle `busy` is 0.

## Configuration
- `DRAIN_SKEW_EN` defined:
  - Lane i of `c_in` passes through `VECTOR`-1-i delay registers before capture. This realigns diagonal-wavefront results so each FIFO entry holds one logical output row.
  - The fill count becomes `ROWS`+`VECTOR`-1.
- `DRAIN_SKEW_EN` undefined: no delay registers; all lanes are captured in the same cycle, matching the broadcast-operand PE array.

## Test plan
- Basic tile: `tile_len`=2, `out_ready`=1, `c_in`=cycle counter on all lanes → 12 words, lanes 0..5 twice. First `out_valid` at T+8, `out_last` on word 12, `busy` low at T+20.
- Back-pressure: `out_ready` toggling 1/0 → no word lost or duplicated, data stable during stall, all 12 words in order.
- Overflow: `DEPTH`=8, `tile_len`=20, `out_ready`=0 until capture ends → `overflow`=1. After release, 8 or 9 vectors emerge (9 when one was popped into the serializer), with `out_last` on the final emitted word.
- Zero and ignored start: `tile_len`=0 → `busy` stays 0. A `start` pulse during FILL does not alter the count or `tile_len`.
- Mid-tile reset: `rst_n`=0 during DRAIN with `out_valid`=1 → next cycle all outputs 0, FSM in IDLE; a subsequent tile behaves as in the basic test.
- Skew (`DRAIN_SKEW_EN`): `c_in[i]` = 100×i + (cycle−i) → each emitted vector has lanes equal to 100×i + k for a common k.
